branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic predictor for conditional micro-jumps (JZE, JNE, JCY) in the MicroEV20 pipeline. At fetch it predicts taken/not-taken from a table of 2-bit saturating counters indexed by the micro-address. It records each prediction in a small in-order queue. The queue head drives the prediction checker in the execute stage (`last_pred`, `pred_type`). The checker's verdict (`checked`, `incorrect_pred`, `correct_pred`) is consumed to pop the queue, train the table and flush speculative entries.

## Interface
- `ADDR_W`, 8: micro-address width.
- `IDX_W`, 4: table index width (2^IDX_W entries); IDX_W <= ADDR_W.
- `Q_DEPTH`, 2: in-flight prediction queue depth; power of two, >= 2.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_valid`  in  1  a micro-instruction is fetched this cycle.
- `fetch_addr`  in  ADDR_W  its micro-address.
- `fetch_type`  in  2  01 JZE, 10 JNE, 11 JCY, 00 not a conditional jump.
- `predict_taken`  out  1  combinational prediction for the current fetch.
- `stall`  out  1  queue full; fetch must hold.
- `head_valid`  out  1  queue non-empty.
- `last_pred`  out  1  prediction of the queue head (to checker).
- `pred_type`  out  2  type of the queue head (to checker).
- `checked`  in  1  checker verdict valid this cycle.
- `incorrect_pred`  in  1  head was mispredicted.
- `correct_pred`  in  1  actual outcome of the head (1 = taken).
- `mispredict_count`  out  16  saturating mispredict counter.
- `err`  out  1  sticky protocol error.

## Operation
- Table:
  - One 2-bit counter per entry; index = `fetch_addr[IDX_W-1:0]`.
  - `predict_taken` = counter[1] when `fetch_type != 00`, else 0.
- Push:
  - Occurs when `fetch_valid` && `fetch_type != 00` && !`stall`.
  - Stores {type, predict_taken, index} at the tail.
  - A push while `stall` = 1 is ignored (fetch holds, so it is re-presented).
- Pop:
  - Occurs when `checked` && `head_valid`.
  - Pops the head and trains the head's table entry with `correct_pred`:
    - outcome 1: increment, saturating at 11.
    - outcome 0: decrement, saturating at 00.
- Mispredict:
  - Triggered by pop && `incorrect_pred`.
  - After the pop the queue is emptied (all younger entries are wrong-path).
  - A push in the same cycle is discarded.
  - `mispredict_count` += 1, saturating at 16'hFFFF.
- Simultaneous push and pop without mispredict: both take effect; occupancy unchanged. This is legal even at full occupancy only if `stall` was 0 (stall depends on registered occupancy, not on `checked`).
- `checked` with queue empty: no pop, no training, `err` set to 1 and held until reset.
- Table read/write collision (fetch index == training index in the same cycle): `predict_taken` uses the pre-update value; the update is visible next cycle.
- Head outputs when empty: `last_pred` = 0, `pred_type` = 00.
- Pointers wrap modulo Q_DEPTH. Occupancy is a counter 0..Q_DEPTH; `stall` = (occupancy == Q_DEPTH).

## Timing
- Reset (asynchronous, immediate):
  - All table counters 01 (weakly not-taken).
  - Queue empty, pointers 0.
  - `mispredict_count` 0, `err` 0.
- Outputs after reset: `predict_taken` 0, `stall` 0, `head_valid` 0, `last_pred` 0, `pred_type` 00.
- `predict_taken`: combinational, same cycle as `fetch_addr`/`fetch_type`.
- Push in cycle N: entry at head no earlier than cycle N+1 (registered storage); `stall` updates in N+1.
- The checker is combinational on the head; a `checked` pulse in cycle N pops at the end of N, and the next head appears in N+1.
- Training, flush, counter and `err` updates all land on the rising edge ending the verdict cycle.
- Reset asserted mid-operation discards all queued predictions and all training in that cycle.

## Test plan
- Reset, then push JZE at addr 0x03 -> `predict_taken` 0; next cycle `head_valid` 1, `last_pred` 0, `pred_type` 01.
- Train addr 0x05 taken three times (push, `checked`=1, `correct_pred`=1) -> counter saturates at 11; fourth fetch `predict_taken` 1; one not-taken verdict -> 10, still predicts 1.
- Push two entries (Q_DEPTH=2) -> `stall` 1; a third push is ignored; pop with correct verdict -> `stall` 0 next cycle, second entry at head.
- Two entries queued, head verdict `incorrect_pred`=1 with a simultaneous push -> queue empty next cycle, `head_valid` 0, `mispredict_count` = 1.
- `checked`=1 with queue empty -> `err` 1 and stays 1; table and count unchanged; reset clears `err`.
- Preload `mispredict_count` to 16'hFFFF via repeated mispredicts (or force) -> one more mispredict leaves it at 16'hFFFF.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/checker-facing signal bundle of the micro-jump branch predictor.
// master = pipeline side (drives fetch and verdicts), slave = predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 8
) ();
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic [1:0]        fetch_type;
    logic              predict_taken;
    logic              stall;
    logic              head_valid;
    logic              last_pred;
    logic [1:0]        pred_type;
    logic              checked;
    logic              incorrect_pred;
    logic              correct_pred;
    logic [15:0]       mispredict_count;
    logic              err;

    modport master (
        output fetch_valid, fetch_addr, fetch_type,
        output checked, incorrect_pred, correct_pred,
        input  predict_taken, stall, head_valid, last_pred, pred_type,
        input  mispredict_count, err
    );

    modport slave (
        input  fetch_valid, fetch_addr, fetch_type,
        input  checked, incorrect_pred, correct_pred,
        output predict_taken, stall, head_valid, last_pred, pred_type,
        output mispredict_count, err
    );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit counter micro-jump predictor with in-order prediction queue; prediction is combinational,
// queue entries reach the head one cycle after push. Fetch is stalled while the queue is full.
module branch_predictor #(
    parameter int ADDR_W  = 8,
    parameter int IDX_W   = 4,
    parameter int Q_DEPTH = 2
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int TBL_N = 1 << IDX_W;
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam logic [PTR_W:0] Q_FULL = (PTR_W + 1)'(Q_DEPTH);

    typedef struct packed {
        logic [1:0]       typ;
        logic             pred;
        logic [IDX_W-1:0] idx;
    } entry_t;

    logic [1:0]        tbl [TBL_N];
    entry_t            q_mem [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic [15:0]       miss_cnt;
    logic              err_q;

    logic [ADDR_W-1:0] fetch_addr;
    logic [IDX_W-1:0]  fetch_idx;
    logic              unused_addr_bits;
    logic              is_cond;
    logic              pred_now;
    logic              q_full;
    logic              q_nonempty;
    logic              push;
    logic              pop;
    logic              flush;
    logic              stray_chk;
    entry_t            head;
    entry_t            fetch_entry;
    logic [1:0]        trained;

    assign fetch_addr       = bp.fetch_addr;
    assign fetch_idx        = fetch_addr[IDX_W-1:0];
    assign unused_addr_bits = ^fetch_addr;

    // Read sees the pre-update counter when it collides with this cycle's training write.
    assign is_cond  = (bp.fetch_type != 2'b00);
    assign pred_now = is_cond & tbl[fetch_idx][1];

    assign q_full     = (occ == Q_FULL);
    assign q_nonempty = (occ != '0);
    assign head       = q_mem[rd_ptr];

    assign push      = bp.fetch_valid & is_cond & ~q_full;
    assign pop       = bp.checked & q_nonempty;
    assign flush     = pop & bp.incorrect_pred;
    assign stray_chk = bp.checked & ~q_nonempty;

    assign fetch_entry = '{typ: bp.fetch_type, pred: pred_now, idx: fetch_idx};

    always_comb begin
        trained = tbl[head.idx];
        if (bp.correct_pred) begin
            if (trained != 2'b11) trained = trained + 2'd1;
        end else begin
            if (trained != 2'b00) trained = trained - 2'd1;
        end
    end

    // A flush drops every younger entry, including one pushed in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                occ <= occ + (PTR_W + 1)'(1);
            else if (pop && !push)
                occ <= occ - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= fetch_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] <= 2'b01;
        end else if (pop) begin
            tbl[head.idx] <= trained;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (flush && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (stray_chk) err_q <= 1'b1;
        end
    end

    assign bp.predict_taken    = pred_now;
    assign bp.stall            = q_full;
    assign bp.head_valid       = q_nonempty;
    assign bp.last_pred        = q_nonempty ? head.pred : 1'b0;
    assign bp.pred_type        = q_nonempty ? head.typ : 2'b00;
    assign bp.mispredict_count = miss_cnt;
    assign bp.err              = err_q;

    occ_bounded: assert property (@(posedge clk) disable iff (reset) occ <= Q_FULL);
    flush_empties: assert property (@(posedge clk) disable iff (reset) flush |=> occ == '0);
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor: reference model feeds a status queue and a
// head scoreboard; a negedge monitor pops and compares against what the DUT presents.
module tb_branch_predictor;
    localparam int ADDR_W  = 8;
    localparam int IDX_W   = 4;
    localparam int Q_DEPTH = 2;
    localparam int TBL_N   = 1 << IDX_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(ADDR_W)) bp_if ();

    branch_predictor #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp_if)
    );

    typedef struct {
        bit          pt;
        bit          stall;
        bit          hv;
        int unsigned mcount;
        bit          err;
    } status_t;

    typedef struct {
        bit [1:0] typ;
        bit       pred;
    } head_t;

    typedef struct {
        int       idx;
        bit [1:0] typ;
        bit       pred;
    } ment_t;

    status_t st_q[$];
    head_t   sb_q[$];

    // Reference model: plain integer counters and a queue of in-flight predictions.
    int          cnt[TBL_N];
    ment_t       mq[$];
    int unsigned mcount;
    bit          merr;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    status_t mon_s;
    head_t   mon_h;

    function automatic void check(string nm, longint unsigned act, longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TBL_N; i++) cnt[i] = 1;
        mq.delete();
        sb_q.delete();
        st_q.delete();
        mcount = 0;
        merr   = 1'b0;
    endfunction

    task automatic drive_idle(bit chk);
        bp_if.fetch_valid    = 1'b0;
        bp_if.fetch_addr     = '0;
        bp_if.fetch_type     = 2'b00;
        bp_if.checked        = chk;
        bp_if.incorrect_pred = 1'b0;
        bp_if.correct_pred   = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        drive_idle(1'b1);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle(1'b0);
        mon_en = 1'b1;
    endtask

    // Drives one cycle at posedge+1, records expectations, advances the model, returns at next posedge+1.
    task automatic cycle(bit fv, bit [7:0] addr, bit [1:0] typ, bit chk, bit inc, bit cor);
        status_t s;
        ment_t   h;
        int      idx;
        int      occ;
        bit      stall_e;
        bit      pt;
        bit      do_pop;
        bit      do_push;
        idx     = int'(addr) % TBL_N;
        occ     = mq.size();
        stall_e = (occ == Q_DEPTH);
        pt      = (typ != 2'b00) && (cnt[idx] >= 2);

        bp_if.fetch_valid    = fv;
        bp_if.fetch_addr     = addr;
        bp_if.fetch_type     = typ;
        bp_if.checked        = chk;
        bp_if.incorrect_pred = inc;
        bp_if.correct_pred   = cor;

        s.pt     = pt;
        s.stall  = stall_e;
        s.hv     = (occ > 0);
        s.mcount = mcount;
        s.err    = merr;
        st_q.push_back(s);

        do_pop  = chk && (occ > 0);
        do_push = fv && (typ != 2'b00) && !stall_e;
        if (chk && occ == 0) merr = 1'b1;
        if (do_pop) begin
            h = mq.pop_front();
            if (cor) begin
                if (cnt[h.idx] < 3) cnt[h.idx]++;
            end else begin
                if (cnt[h.idx] > 0) cnt[h.idx]--;
            end
        end
        if (do_pop && inc) begin
            mq.delete();
            if (mcount < 32'hFFFF) mcount++;
        end else if (do_push) begin
            mq.push_back('{idx, typ, pt});
            sb_q.push_back('{typ, pt});
        end

        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL status_queue: actual empty required entry at %0t", $time);
            end else begin
                mon_s = st_q.pop_front();
                check("predict_taken", bp_if.predict_taken, mon_s.pt);
                check("stall", bp_if.stall, mon_s.stall);
                check("head_valid", bp_if.head_valid, mon_s.hv);
                check("mispredict_count", bp_if.mispredict_count, mon_s.mcount);
                check("err", bp_if.err, mon_s.err);
            end
            if (bp_if.head_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL head_scoreboard: actual head present required none at %0t", $time);
                end else begin
                    mon_h = sb_q[0];
                    check("last_pred", bp_if.last_pred, mon_h.pred);
                    check("pred_type", bp_if.pred_type, mon_h.typ);
                    if (bp_if.checked) begin
                        void'(sb_q.pop_front());
                        if (bp_if.incorrect_pred) sb_q.delete();
                    end
                end
            end else begin
                check("last_pred_empty", bp_if.last_pred, 0);
                check("pred_type_empty", bp_if.pred_type, 0);
            end
        end
    end

    initial begin
        bit          fv;
        bit [7:0]    addr;
        bit [1:0]    typ;
        bit          chk;
        bit          inc;
        bit          cor;

        do_reset();

        // First push after reset: weakly not-taken, JZE lands at head next cycle.
        cycle(1, 8'h03, 2'b01, 0, 0, 0);
        cycle(0, 8'h00, 2'b00, 0, 0, 0);
        cycle(0, 8'h00, 2'b00, 1, 0, 0);

        // Saturate addr 0x05 taken, then one not-taken verdict keeps it predicting taken.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h05, 2'b01, 0, 0, 0);
            cycle(0, 8'h00, 2'b00, 1, 0, 1);
        end
        cycle(1, 8'h05, 2'b10, 0, 0, 0);
        cycle(0, 8'h00, 2'b00, 1, 0, 0);
        cycle(1, 8'h05, 2'b11, 0, 0, 0);
        cycle(0, 8'h00, 2'b00, 1, 0, 1);

        // Fill to full, ignored third push, pop frees one slot.
        cycle(1, 8'h10, 2'b10, 0, 0, 0);
        cycle(1, 8'h11, 2'b11, 0, 0, 0);
        cycle(1, 8'h12, 2'b01, 0, 0, 0);
        cycle(1, 8'h12, 2'b01, 1, 0, 0);
        cycle(0, 8'h00, 2'b00, 1, 0, 0);

        // Mispredict with a simultaneous push empties the queue.
        cycle(1, 8'h20, 2'b01, 0, 0, 0);
        cycle(1, 8'h21, 2'b10, 0, 0, 0);
        cycle(1, 8'h22, 2'b11, 1, 1, 1);
        check("flush_head_valid", bp_if.head_valid, 0);
        check("flush_count", bp_if.mispredict_count, 1);

        // Verdict with empty queue sets sticky err.
        cycle(0, 8'h00, 2'b00, 1, 0, 1);
        check("err_set", bp_if.err, 1);
        cycle(1, 8'h05, 2'b01, 0, 0, 0);
        cycle(0, 8'h00, 2'b00, 0, 0, 0);
        check("err_sticky", bp_if.err, 1);

        // Asynchronous reset with entries queued clears outputs before any clock edge.
        cycle(1, 8'h30, 2'b01, 0, 0, 0);
        mon_en = 1'b0;
        drive_idle(1'b1);
        reset = 1'b1;
        #2;
        check("arst_head_valid", bp_if.head_valid, 0);
        check("arst_stall", bp_if.stall, 0);
        check("arst_err", bp_if.err, 0);
        check("arst_count", bp_if.mispredict_count, 0);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            fv   = ($urandom_range(0, 9) < 7);
            addr = 8'($urandom_range(0, 255));
            typ  = 2'($urandom_range(0, 3));
            chk  = ($urandom_range(0, 9) < 4);
            inc  = ($urandom_range(0, 9) < 2);
            cor  = 1'($urandom_range(0, 1));
            cycle(fv, addr, typ, chk, inc, cor);
        end

        // Counter saturation: preload near the top, then two more mispredicts.
        do_reset();
        force dut.miss_cnt = 16'hFFFE;
        #1;
        release dut.miss_cnt;
        mcount = 32'hFFFE;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 8'h40, 2'b01, 0, 0, 0);
            cycle(1, 8'h41, 2'b10, 1, 1, 0);
        end
        check("count_saturated", bp_if.mispredict_count, 16'hFFFF);
        cycle(0, 8'h00, 2'b00, 0, 0, 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
